// File: rtl/scpu_ctrl_pkg.sv
// Shared SCPU control encodings: opcodes, datapath select codes, the multi-cycle
// state enum and the decoded-instruction record.
package scpu_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [5:0] EXT_NONE  = 6'b000000;
    localparam logic [5:0] EXT_ITYPE = 6'b010000;
    localparam logic [5:0] EXT_STYPE = 6'b001000;
    localparam logic [5:0] EXT_BTYPE = 6'b000100;
    localparam logic [5:0] EXT_UTYPE = 6'b000010;
    localparam logic [5:0] EXT_JTYPE = 6'b000001;

    localparam logic [4:0] ALU_NONE = 5'b00000;
    localparam logic [4:0] ALU_LUI  = 5'b00001;
    localparam logic [4:0] ALU_ADD  = 5'b00011;
    localparam logic [4:0] ALU_SUB  = 5'b00100;
    localparam logic [4:0] ALU_XOR  = 5'b01100;
    localparam logic [4:0] ALU_OR   = 5'b01101;
    localparam logic [4:0] ALU_AND  = 5'b01110;

    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;

    localparam logic [2:0] DM_WORD  = 3'b000;
    localparam logic [2:0] DM_HALF  = 3'b001;
    localparam logic [2:0] DM_HALFU = 3'b010;
    localparam logic [2:0] DM_BYTE  = 3'b011;
    localparam logic [2:0] DM_BYTEU = 3'b100;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef struct packed {
        logic       illegal;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       is_bne;
        logic       is_jal;
        logic       is_jalr;
        logic [5:0] ext_op;
        logic [4:0] alu_op;
        logic       alu_src;
        logic [1:0] wd_sel;
        logic [2:0] dm_type;
    } dec_t;

    // Load/store width code from funct3 (stores only use the low three codes).
    function automatic logic [2:0] dm_type_of(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return DM_BYTE;
            3'b001:  return DM_HALF;
            3'b100:  return DM_BYTEU;
            3'b101:  return DM_HALFU;
            default: return DM_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Instruction/data memory request handshakes between the control unit and memories.
// req rises when the controller wants a transfer and stays high until the cycle in
// which ready is seen; the transfer completes in that ready cycle and nowhere else.
interface mc_ctrl_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_ready;

    modport master (output imem_req, output dmem_req, input imem_ready, input dmem_ready);
    modport slave  (input imem_req, input dmem_req, output imem_ready, output dmem_ready);
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational RV32I-subset classifier: control encodings plus illegal detection.
module mc_ctrl_decode
    import scpu_ctrl_pkg::*;
(
    input  logic [6:0] op,
    input  logic [6:0] funct7,
    input  logic [2:0] funct3,
    output dec_t       dec
);

    logic       logic_f3_ok;
    logic [4:0] logic_alu;

    // funct3 codes shared by the register and immediate ALU forms.
    assign logic_f3_ok = funct3 inside {3'b000, 3'b100, 3'b110, 3'b111};

    always_comb begin
        case (funct3)
            3'b100:  logic_alu = ALU_XOR;
            3'b110:  logic_alu = ALU_OR;
            3'b111:  logic_alu = ALU_AND;
            default: logic_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        dec         = '0;
        dec.ext_op  = EXT_NONE;
        dec.alu_op  = ALU_NONE;
        dec.wd_sel  = WD_ALU;
        dec.dm_type = DM_WORD;
        case (op)
            OP_R: begin
                dec.alu_op  = (funct3 == 3'b000 && funct7 == F7_ALT) ? ALU_SUB : logic_alu;
                dec.illegal = !((funct7 == F7_BASE && logic_f3_ok) ||
                                (funct7 == F7_ALT && funct3 == 3'b000));
            end
            OP_I: begin
                dec.ext_op  = EXT_ITYPE;
                dec.alu_op  = logic_alu;
                dec.alu_src = 1'b1;
                dec.illegal = !logic_f3_ok;
            end
            OP_LOAD: begin
                dec.is_load = 1'b1;
                dec.ext_op  = EXT_ITYPE;
                dec.alu_op  = ALU_ADD;
                dec.alu_src = 1'b1;
                dec.wd_sel  = WD_MEM;
                dec.dm_type = dm_type_of(funct3);
                dec.illegal = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
            end
            OP_STORE: begin
                dec.is_store = 1'b1;
                dec.ext_op   = EXT_STYPE;
                dec.alu_op   = ALU_ADD;
                dec.alu_src  = 1'b1;
                dec.dm_type  = dm_type_of(funct3);
                dec.illegal  = !(funct3 inside {3'b000, 3'b001, 3'b010});
            end
            OP_BRANCH: begin
                dec.is_branch = 1'b1;
                dec.is_bne    = funct3[0];
                dec.ext_op    = EXT_BTYPE;
                dec.alu_op    = ALU_SUB;
                dec.illegal   = !(funct3 inside {3'b000, 3'b001});
            end
            OP_LUI: begin
                dec.ext_op  = EXT_UTYPE;
                dec.alu_op  = ALU_LUI;
                dec.alu_src = 1'b1;
            end
            OP_JAL: begin
                dec.is_jal = 1'b1;
                dec.ext_op = EXT_JTYPE;
                dec.wd_sel = WD_PC;
            end
            OP_JALR: begin
                dec.is_jalr = 1'b1;
                dec.ext_op  = EXT_ITYPE;
                dec.alu_op  = ALU_ADD;
                dec.alu_src = 1'b1;
                dec.wd_sel  = WD_PC;
                dec.illegal = (funct3 != 3'b000);
            end
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle SCPU control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with memory
// wait timeout and a sticky trap.
module mc_ctrl
    import scpu_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [6:0]       Op,
    input  logic [6:0]       Funct7,
    input  logic [2:0]       Funct3,
    input  logic             Zero,
    mc_ctrl_if.master        mem,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [5:0]       EXTOp,
    output logic [4:0]       ALUOp,
    output logic [2:0]       NPCOp,
    output logic             ALUSrc,
    output logic [1:0]       WDSel,
    output logic [2:0]       DMType,
    output logic             trap,
    output logic             trap_cause,
    output state_t           state
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_t            state_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              trap_q;
    logic              cause_q;
    dec_t              dec;

    mc_ctrl_decode u_decode (
        .op     (Op),
        .funct7 (Funct7),
        .funct3 (Funct3),
        .dec    (dec)
    );

    // A stalled cycle whose count would reach MAX_WAIT traps; ready in that cycle wins.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= S_FETCH;
            wait_cnt <= '0;
            trap_q   <= 1'b0;
            cause_q  <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (mem.imem_ready) begin
                        state_q <= S_DECODE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state_q <= S_TRAP;
                        trap_q  <= 1'b1;
                        cause_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_DECODE: begin
                    if (dec.illegal) begin
                        state_q <= S_TRAP;
                        trap_q  <= 1'b1;
                        cause_q <= 1'b0;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (dec.is_branch) begin
                        state_q  <= S_FETCH;
                        wait_cnt <= '0;
                    end else if (dec.is_load || dec.is_store) begin
                        state_q  <= S_MEM;
                        wait_cnt <= '0;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem.dmem_ready) begin
                        state_q  <= dec.is_load ? S_WB : S_FETCH;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state_q <= S_TRAP;
                        trap_q  <= 1'b1;
                        cause_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_WB: begin
                    state_q  <= S_FETCH;
                    wait_cnt <= '0;
                end
                S_TRAP:  state_q <= S_TRAP;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Outputs are forced to their reset values for as long as rstn is held low.
    always_comb begin
        PCWrite      = 1'b0;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        MemWrite     = 1'b0;
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        EXTOp        = EXT_NONE;
        ALUOp        = ALU_NONE;
        NPCOp        = NPC_PLUS4;
        ALUSrc       = 1'b0;
        WDSel        = WD_ALU;
        DMType       = DM_WORD;
        if (rstn) begin
            if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
                EXTOp  = dec.ext_op;
                ALUOp  = dec.alu_op;
                ALUSrc = dec.alu_src;
                WDSel  = dec.wd_sel;
                DMType = dec.dm_type;
            end
            case (state_q)
                S_FETCH: begin
                    mem.imem_req = 1'b1;
                    IRWrite      = mem.imem_ready;
                end
                S_EXEC: begin
                    if (dec.is_branch) begin
                        PCWrite = 1'b1;
                        if (dec.is_bne ? !Zero : Zero) NPCOp = NPC_BRANCH;
                    end
                end
                S_MEM: begin
                    mem.dmem_req = 1'b1;
                    if (mem.dmem_ready && dec.is_store) begin
                        MemWrite = 1'b1;
                        PCWrite  = 1'b1;
                    end
                end
                S_WB: begin
                    RegWrite = 1'b1;
                    PCWrite  = 1'b1;
                    if (dec.is_jal)       NPCOp = NPC_JUMP;
                    else if (dec.is_jalr) NPCOp = NPC_JALR;
                end
                default: ;
            endcase
        end
    end

    assign trap       = trap_q;
    assign trap_cause = cause_q;
    assign state      = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl (MAX_WAIT=4): cycle counts, strobes and encodings per
// instruction class, wait timeout boundary, illegal trap and reset recovery.
module tb_mc_ctrl;
    import scpu_ctrl_pkg::*;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic [6:0] Op = '0, Funct7 = '0;
    logic [2:0] Funct3 = '0;
    logic       Zero = 1'b0;
    logic       PCWrite, IRWrite, RegWrite, MemWrite, ALUSrc, trap, trap_cause;
    logic [5:0] EXTOp;
    logic [4:0] ALUOp;
    logic [2:0] NPCOp, DMType;
    logic [1:0] WDSel;
    state_t     state;

    mc_ctrl_if bus ();

    mc_ctrl #(.MAX_WAIT(4)) dut (
        .clk(clk), .rstn(rstn), .Op(Op), .Funct7(Funct7), .Funct3(Funct3), .Zero(Zero),
        .mem(bus), .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .EXTOp(EXTOp), .ALUOp(ALUOp), .NPCOp(NPCOp), .ALUSrc(ALUSrc),
        .WDSel(WDSel), .DMType(DMType), .trap(trap), .trap_cause(trap_cause), .state(state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Per-instruction observations collected by run().
    int         cyc_n, n_pcw, n_regw, n_memw, n_irw, n_mem;
    logic [2:0] exec_npc, wb_npc, mem_dm;
    logic       exec_pcw;
    logic [1:0] wb_wd;
    logic [4:0] wb_alu;
    logic [5:0] wb_ext;
    logic [2:0] got_q[$];
    logic [2:0] exp_q[$];

    task automatic set_ir(input logic [31:0] ir);
        Op     = ir[6:0];
        Funct3 = ir[14:12];
        Funct7 = ir[31:25];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        tick();
        rstn = 1'b1;
        #1;
    endtask

    // Drives one instruction from FETCH until it returns to FETCH or reaches TRAP.
    task automatic run(input logic [31:0] ir, input logic zero, input int iwait, input int dwait);
        int fc = 0;
        int mc = 0;
        bit left = 0;
        cyc_n = 0; n_pcw = 0; n_regw = 0; n_memw = 0; n_irw = 0; n_mem = 0;
        exec_npc = 'x; exec_pcw = 1'b0; wb_npc = 'x; mem_dm = 'x;
        wb_wd = 'x; wb_alu = 'x; wb_ext = 'x;
        got_q.delete();
        set_ir(ir);
        Zero = zero;
        for (int k = 0; k < 40; k++) begin
            bus.imem_ready = (state == S_FETCH) && (fc >= iwait);
            bus.dmem_ready = (state == S_MEM) && (mc >= dwait);
            #1;
            got_q.push_back(state);
            n_pcw  += int'(PCWrite);
            n_regw += int'(RegWrite);
            n_memw += int'(MemWrite);
            n_irw  += int'(IRWrite);
            case (state)
                S_FETCH: fc++;
                S_EXEC: begin exec_npc = NPCOp; exec_pcw = PCWrite; end
                S_MEM: begin mc++; n_mem++; mem_dm = DMType; end
                S_WB: begin wb_npc = NPCOp; wb_wd = WDSel; wb_alu = ALUOp; wb_ext = EXTOp; end
                default: ;
            endcase
            tick();
            cyc_n++;
            bus.imem_ready = 1'b0;
            bus.dmem_ready = 1'b0;
            if (state == S_TRAP) return;
            if (state != S_FETCH) left = 1;
            else if (left) return;
        end
        check("run_bound", state, S_FETCH);
    endtask

    initial begin
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;

        // Reset held low across two edges.
        tick();
        tick();
        check("rst_state", state, S_FETCH);
        check("rst_imem_req", bus.imem_req, 0);
        check("rst_strobes", {PCWrite, IRWrite, RegWrite, MemWrite, bus.dmem_req}, 0);
        check("rst_trap", {trap, trap_cause}, 0);
        check("rst_enc", {EXTOp, ALUOp, NPCOp, ALUSrc, WDSel, DMType}, 0);
        rstn = 1'b1;
        #1;
        check("rel_imem_req", bus.imem_req, 1);

        // add x3,x1,x2
        run(32'h002081B3, 1'b0, 0, 0);
        check("add_cycles", cyc_n, 4);
        exp_q = '{S_FETCH, S_DECODE, S_EXEC, S_WB};
        check("add_trace_len", got_q.size(), 4);
        while (exp_q.size() > 0 && got_q.size() > 0)
            check("add_trace", got_q.pop_front(), exp_q.pop_front());
        check("add_irw", n_irw, 1);
        check("add_regw", n_regw, 1);
        check("add_pcw", n_pcw, 1);
        check("add_alu", wb_alu, 5'b00011);
        check("add_npc", wb_npc, 3'b000);
        check("add_wd", wb_wd, 2'b00);

        // lbu with three data stall cycles; ready lands exactly at the wait limit.
        run(32'h0000C083, 1'b0, 0, 3);
        check("lbu_cycles", cyc_n, 8);
        check("lbu_mem_cycles", n_mem, 4);
        check("lbu_dm", mem_dm, 3'b100);
        check("lbu_wd", wb_wd, 2'b01);
        check("lbu_regw", n_regw, 1);
        check("lbu_pcw", n_pcw, 1);
        check("lbu_trap", trap, 0);

        // beq / bne with Zero=1
        run(32'h00000063, 1'b1, 0, 0);
        check("beq_cycles", cyc_n, 3);
        check("beq_npc", exec_npc, 3'b001);
        check("beq_pcw_exec", exec_pcw, 1);
        check("beq_pcw", n_pcw, 1);
        check("beq_regw", n_regw, 0);
        run(32'h00001063, 1'b1, 0, 0);
        check("bne_cycles", cyc_n, 3);
        check("bne_npc", exec_npc, 3'b000);
        check("bne_regw", n_regw, 0);

        // sw x1,0(x0)
        run(32'h00102023, 1'b0, 0, 0);
        check("sw_cycles", cyc_n, 4);
        check("sw_memw", n_memw, 1);
        check("sw_regw", n_regw, 0);
        check("sw_pcw", n_pcw, 1);
        check("sw_dm", mem_dm, 3'b000);

        // jalr, sub, lui, jal
        run(32'h000080E7, 1'b0, 0, 0);
        check("jalr_cycles", cyc_n, 4);
        check("jalr_wd", wb_wd, 2'b10);
        check("jalr_npc", wb_npc, 3'b100);
        check("jalr_ext", wb_ext, 6'b010000);
        run(32'h402081B3, 1'b0, 0, 0);
        check("sub_alu", wb_alu, 5'b00100);
        run(32'h123450B7, 1'b0, 0, 0);
        check("lui_alu", wb_alu, 5'b00001);
        check("lui_ext", wb_ext, 6'b000010);
        run(32'h008000EF, 1'b0, 0, 0);
        check("jal_npc", wb_npc, 3'b010);
        check("jal_wd", wb_wd, 2'b10);

        // Reset while a store waits in MEM with ready in flight.
        set_ir(32'h00102023);
        bus.imem_ready = 1'b1;
        for (int k = 0; k < 6 && state != S_MEM; k++) tick();
        bus.imem_ready = 1'b0;
        check("mid_in_mem", state, S_MEM);
        rstn = 1'b0;
        bus.dmem_ready = 1'b1;
        #1;
        check("mid_memw", MemWrite, 0);
        tick();
        bus.dmem_ready = 1'b0;
        check("mid_state", state, S_FETCH);
        check("mid_dmem_req", bus.dmem_req, 0);
        rstn = 1'b1;
        #1;

        // Fetch ready on the fourth stalled cycle: no trap.
        run(32'h002081B3, 1'b0, 3, 0);
        check("fw3_cycles", cyc_n, 7);
        check("fw3_trap", trap, 0);
        check("fw3_state", state, S_FETCH);

        // Fetch never ready: timeout after four stall cycles.
        run(32'h002081B3, 1'b0, 100, 0);
        check("to_cycles", cyc_n, 4);
        check("to_state", state, S_TRAP);
        check("to_trap", {trap, trap_cause}, 2'b11);
        do_reset();
        check("to_rst_state", state, S_FETCH);
        check("to_rst_trap", trap, 0);

        // Illegal opcode: trap held, strobes silent, reset recovers.
        run(32'h0000007F, 1'b0, 0, 0);
        check("ill_cycles", cyc_n, 2);
        check("ill_trap", {trap, trap_cause}, 2'b10);
        for (int k = 0; k < 20; k++) begin
            bus.imem_ready = 1'b1;
            bus.dmem_ready = 1'b1;
            #1;
            check("ill_quiet", {PCWrite, IRWrite, RegWrite, MemWrite, bus.imem_req, bus.dmem_req, trap}, 7'b0000001);
            tick();
        end
        do_reset();
        check("ill_rst_state", state, S_FETCH);
        check("ill_rst_req", bus.imem_req, 1);
        check("ill_rst_trap", trap, 0);

        // R-type with unsupported funct7 (mul) is illegal.
        run(32'h022081B3, 1'b0, 0, 0);
        check("mul_trap", {trap, trap_cause}, 2'b10);
        do_reset();

        // Recovery: plain add after traps.
        run(32'h002081B3, 1'b0, 0, 0);
        check("post_cycles", cyc_n, 4);
        check("post_regw", n_regw, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
